// File: rtl/act_quant_pkg.sv
// Shared constants, types and lane helpers for the activation quantize pipeline.
package act_quant_pkg;

    localparam int OFM_BIT        = 29;
    localparam int IFM_BIT        = 8;
    localparam int LANES          = 4;
    localparam int CH_NUM_DEFAULT = 512;
    localparam int SHIFT_BIT      = 5;
    localparam bit ROUND_EN       = 1'b1;

    localparam int CH_W          = $clog2(CH_NUM_DEFAULT);
    localparam int DEFAULT_SHIFT = OFM_BIT - IFM_BIT;
    localparam int UMAX          = (32'sd1 <<< IFM_BIT) - 32'sd1;
    localparam int SMAX          = (32'sd1 <<< (IFM_BIT - 1)) - 32'sd1;
    localparam int SMIN          = -(32'sd1 <<< (IFM_BIT - 1));

    typedef logic signed [OFM_BIT-1:0]   ofm_t;
    typedef logic        [IFM_BIT-1:0]   act_t;
    typedef logic        [SHIFT_BIT-1:0] shift_t;
    typedef logic [LANES*OFM_BIT-1:0]    ofm_bus_t;
    typedef logic [LANES*IFM_BIT-1:0]    act_bus_t;

    function automatic ofm_t ofm_lane(input ofm_bus_t bus, input int lane);
        return ofm_t'(bus[lane*OFM_BIT +: OFM_BIT]);
    endfunction

    function automatic act_bus_t act_lane_put(input act_bus_t bus, input int lane, input act_t v);
        act_bus_t res;
        res = bus;
        res[lane*IFM_BIT +: IFM_BIT] = v;
        return res;
    endfunction

    // Shifting by OFM_BIT or more would discard the sign; cap at OFM_BIT-1.
    function automatic shift_t clamp_shift(input shift_t s);
        if (s >= shift_t'(OFM_BIT)) begin
            return shift_t'(OFM_BIT - 1);
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/act_quant_pipe_if.sv
// Input/output stream bundle of the activation quantize pipeline.
interface act_quant_pipe_if;
    import act_quant_pkg::*;

    logic     in_valid;
    logic     in_ready;
    logic     in_last;
    ofm_bus_t OFM;
    logic     out_valid;
    logic     out_ready;
    act_bus_t Activation;
    logic     out_last;

    modport master (
        output in_valid, in_last, OFM, out_ready,
        input  in_ready, out_valid, Activation, out_last
    );

    modport slave (
        input  in_valid, in_last, OFM, out_ready,
        output in_ready, out_valid, Activation, out_last
    );

endinterface

// File: rtl/act_lane_quant.sv
// One lane: arithmetic shift with optional round-half-up, then ReLU or signed saturation.
module act_lane_quant
    import act_quant_pkg::*;
(
    input  ofm_t   x,
    input  shift_t shift,
    input  logic   relu_en,
    output act_t   q
);

    typedef logic signed [OFM_BIT:0] wide_t;

    localparam wide_t UMAX_W = wide_t'(UMAX);
    localparam wide_t SMAX_W = wide_t'(SMAX);
    localparam wide_t SMIN_W = wide_t'(SMIN);

    wide_t rnd_s;
    wide_t sum_s;
    wide_t res_s;

    // Rounding offset, one-bit-wider add, shift and clamp to the output range
    always_comb begin
        rnd_s = '0;
        sum_s = '0;
        res_s = '0;
        q     = '0;
        if (ROUND_EN && (shift != '0)) begin
            rnd_s = wide_t'(1) << (shift - shift_t'(1));
        end else begin
            rnd_s = '0;
        end
        sum_s = wide_t'(x) + rnd_s;
        res_s = sum_s >>> shift;
        if (relu_en) begin
            if (x[OFM_BIT-1]) begin
                q = '0;
            end else if (res_s > UMAX_W) begin
                q = act_t'(UMAX);
            end else begin
                q = res_s[IFM_BIT-1:0];
            end
        end else begin
            if (res_s > SMAX_W) begin
                q = act_t'(SMAX);
            end else if (res_s < SMIN_W) begin
                q = act_t'(SMIN);
            end else begin
                q = res_s[IFM_BIT-1:0];
            end
        end
    end

endmodule

// File: rtl/act_quant_pipe.sv
// Multi-lane quantize/ReLU stage: per-channel shift table, channel counter and a
// two-stage valid/ready pipeline (S1 capture, S2 output register).
module act_quant_pipe #(
    parameter int CH_NUM = act_quant_pkg::CH_NUM_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_we,
    input  logic [$clog2(CH_NUM)-1:0]            cfg_ch,
    input  logic [act_quant_pkg::SHIFT_BIT-1:0]  cfg_shift,
    input  logic                                 cfg_relu_en,
    act_quant_pipe_if.slave                      bus
);
    import act_quant_pkg::*;

    localparam int                CH_W_L  = $clog2(CH_NUM);
    localparam logic [CH_W_L-1:0] CH_LAST = CH_W_L'(CH_NUM - 1);

    shift_t            shift_tbl_r [CH_NUM];
    logic [CH_W_L-1:0] ch_cnt_r;

    logic     s1_valid_r;
    logic     s1_last_r;
    logic     s1_relu_r;
    ofm_bus_t s1_ofm_r;
    shift_t   s1_shift_r;

    logic     s2_valid_r;
    logic     s2_last_r;
    act_bus_t s2_act_r;

    logic     in_ready_s;
    logic     accept_s;
    logic     s2_load_s;
    act_t     lane_q_s [LANES];
    act_bus_t act_s;

    // Stage advance: a stage loads when empty or when its content leaves this cycle
    always_comb begin
        s2_load_s  = s1_valid_r && (!s2_valid_r || bus.out_ready);
        in_ready_s = !(s1_valid_r && s2_valid_r && !bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Channel counter; in_last overrides both increment and wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_r <= '0;
        end else if (accept_s) begin
            if (bus.in_last || (ch_cnt_r == CH_LAST)) begin
                ch_cnt_r <= '0;
            end else begin
                ch_cnt_r <= ch_cnt_r + CH_W_L'(1);
            end
        end
    end

    // Shift table; a write lands after the edge so a same-cycle accept sees the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                shift_tbl_r[i] <= shift_t'(DEFAULT_SHIFT);
            end
        end else if (cfg_we) begin
            shift_tbl_r[cfg_ch] <= cfg_shift;
        end
    end

    // S1: capture the beat together with its channel's clamped shift and mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_relu_r  <= 1'b0;
            s1_ofm_r   <= '0;
            s1_shift_r <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_last_r  <= bus.in_last;
            s1_relu_r  <= cfg_relu_en;
            s1_ofm_r   <= bus.OFM;
            s1_shift_r <= clamp_shift(shift_tbl_r[ch_cnt_r]);
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane_quant u_lane (
            .x       (ofm_lane(s1_ofm_r, g)),
            .shift   (s1_shift_r),
            .relu_en (s1_relu_r),
            .q       (lane_q_s[g])
        );
    end

    // Pack lane results into the output bus layout
    always_comb begin
        act_s = '0;
        for (int i = 0; i < LANES; i++) begin
            act_s = act_lane_put(act_s, i, lane_q_s[i]);
        end
    end

    // S2 output register; data only changes on load so it holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_act_r   <= '0;
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            s2_last_r  <= s1_last_r;
            s2_act_r   <= act_s;
        end else if (bus.out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = s2_valid_r;
    assign bus.Activation = s2_act_r;
    assign bus.out_last   = s2_last_r;

endmodule
